// File: rtl/command_frame_tx_if.sv
// Byte-stream link between the frame transmitter, its host,
// the payload RAM and the UART TX byte port.
interface command_frame_tx_if #(
  parameter int WORD_LENGTH = 8,
  parameter int ADDR_WIDTH  = 4
);
  logic                   start;
  logic [WORD_LENGTH-1:0] payload_length;
  logic [WORD_LENGTH-1:0] command_id;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [WORD_LENGTH-1:0] rd_data;
  logic [WORD_LENGTH-1:0] tx_data;
  logic                   tx_send;
  logic                   tx_done;
  logic                   busy;
  logic                   done;
  logic                   error;

  modport master (
    output start, payload_length, command_id,
    output rd_data, tx_done,
    input  rd_addr, tx_data, tx_send,
    input  busy, done, error
  );

  modport slave (
    input  start, payload_length, command_id,
    input  rd_data, tx_done,
    output rd_addr, tx_data, tx_send,
    output busy, done, error
  );
endinterface

// File: rtl/command_frame_tx.sv
// Serializes FE, N, cmd, payload[0..N-1], XOR checksum, EF
// into single-byte UART transfers.
module command_frame_tx #(
  parameter int WORD_LENGTH = 8,
  parameter int MAX_LEN     = 16,
  parameter int ADDR_WIDTH  = 4
) (
  input logic               clk,
  input logic               reset,
  command_frame_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH,
    S_SEND, S_WAIT, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    F_HDR, F_LEN, F_CMD,
    F_PAY, F_CHK, F_TAIL
  } field_t;

  localparam logic [WORD_LENGTH-1:0] HDR =
    WORD_LENGTH'(8'hFE);
  localparam logic [WORD_LENGTH-1:0] TAIL =
    WORD_LENGTH'(8'hEF);
  localparam logic [WORD_LENGTH-1:0] MAXN =
    WORD_LENGTH'(MAX_LEN);
  localparam logic [WORD_LENGTH-1:0] ONE =
    WORD_LENGTH'(1);

  state_t                 state_q, state_d;
  field_t                 field_q, field_d;
  logic [WORD_LENGTH-1:0] len_q, len_d;
  logic [WORD_LENGTH-1:0] cmd_q, cmd_d;
  logic [WORD_LENGTH-1:0] chk_q, chk_d;
  logic [WORD_LENGTH-1:0] txd_q, txd_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic                   err_q, err_d;
  logic                   len_ok;
  logic                   pay_last;

  assign len_ok = (bus.payload_length != '0) &&
                  (bus.payload_length <= MAXN);

  assign pay_last =
    (WORD_LENGTH'(idx_q) == len_q - ONE);

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    chk_d   = chk_q;
    txd_d   = txd_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && len_ok) begin
          len_d   = bus.payload_length;
          cmd_d   = bus.command_id;
          field_d = F_HDR;
          idx_d   = '0;
          chk_d   = '0;
          state_d = S_LOAD;
        end else if (bus.start) begin
          err_d = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_SEND;
        unique case (field_q)
          F_HDR: txd_d = HDR;
          F_LEN: txd_d = len_q;
          F_CMD: begin
            txd_d = cmd_q;
            chk_d = chk_q ^ cmd_q;
          end
          F_PAY: begin
            txd_d = bus.rd_data;
            chk_d = chk_q ^ bus.rd_data;
          end
          F_CHK: txd_d = chk_q;
          default: txd_d = TAIL;
        endcase
      end
      S_FETCH: state_d = S_LOAD;
      S_SEND:  state_d = S_WAIT;
      S_WAIT: begin
        // Only a tx_done seen here counts; elsewhere it is stray.
        if (bus.tx_done) begin
          unique case (field_q)
            F_HDR: begin
              field_d = F_LEN;
              state_d = S_LOAD;
            end
            F_LEN: begin
              field_d = F_CMD;
              state_d = S_LOAD;
            end
            F_CMD: begin
              field_d = F_PAY;
              state_d = S_FETCH;
            end
            F_PAY: begin
              if (pay_last) begin
                field_d = F_CHK;
                state_d = S_LOAD;
              end else begin
                idx_d   = idx_q + ADDR_WIDTH'(1);
                state_d = S_FETCH;
              end
            end
            F_CHK: begin
              field_d = F_TAIL;
              state_d = S_LOAD;
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      field_q <= F_HDR;
      len_q   <= '0;
      cmd_q   <= '0;
      chk_q   <= '0;
      txd_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      chk_q   <= chk_d;
      txd_q   <= txd_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign bus.rd_addr = idx_q;
  assign bus.tx_data = txd_q;
  assign bus.tx_send = (state_q == S_SEND);
  assign bus.done    = (state_q == S_DONE);
  assign bus.busy    = (state_q != S_IDLE) &&
                       (state_q != S_DONE);
  assign bus.error   = err_q;

endmodule

// File: tb/tb_command_frame_tx.sv
// Directed bench for command_frame_tx: sync RAM model,
// auto-answering UART and byte/pulse monitors.
module tb_command_frame_tx;

  localparam int WL = 8;
  localparam int ML = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  command_frame_tx_if #(
    .WORD_LENGTH(WL), .ADDR_WIDTH(AW)
  ) bus ();

  command_frame_tx #(
    .WORD_LENGTH(WL), .MAX_LEN(ML), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [7:0] mem [16];
  logic [7:0] bytes [256];
  int n_send = 0;
  int n_done = 0;
  int n_err = 0;
  int addr_back = 0;
  logic [3:0] prev_addr = '0;
  logic prev_busy = 1'b0;

  int errors = 0;
  int checks = 0;

  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  always @(posedge clk) begin
    if (reset) begin
      if (bus.tx_send) begin
        bytes[n_send[7:0]] <= bus.tx_data;
        n_send <= n_send + 1;
      end
      if (bus.done) n_done <= n_done + 1;
      if (bus.error) n_err <= n_err + 1;
      if (bus.busy && prev_busy &&
          bus.rd_addr < prev_addr)
        addr_back <= addr_back + 1;
      prev_addr <= bus.rd_addr;
      prev_busy <= bus.busy;
    end
  end

  int cd = 0;
  logic auto_done = 1'b0;
  logic prev_auto = 1'b0;
  logic stray_en = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cd <= 0;
      auto_done <= 1'b0;
      prev_auto <= 1'b0;
    end else begin
      auto_done <= 1'b0;
      prev_auto <= auto_done;
      if (bus.tx_send) cd <= 2;
      else if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) auto_done <= 1'b1;
      end
    end
  end

  assign bus.tx_done = auto_done |
    (stray_en & (bus.tx_send | prev_auto));

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(
    input int i, input int n, input logic [7:0] cmd);
    logic [7:0] c;
    c = cmd;
    for (int j = 0; j < n; j++) c = c ^ mem[j];
    if (i == 0) return 8'hFE;
    if (i == 1) return n[7:0];
    if (i == 2) return cmd;
    if (i < n + 3) return mem[i-3];
    if (i == n + 3) return c;
    return 8'hEF;
  endfunction

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < 500) begin
      cyc(1);
      k++;
    end
    check(tag, bus.done, 1);
  endtask

  task automatic frame(input int n,
                       input logic [7:0] cmd,
                       input bit hold,
                       output int base);
    int d0;
    base = n_send;
    d0 = n_done;
    bus.payload_length = n[7:0];
    bus.command_id = cmd;
    bus.start = 1'b1;
    cyc(1);
    if (!hold) bus.start = 1'b0;
    bus.payload_length = 8'd3;
    bus.command_id = 8'hFF;
    check("busy_c1", bus.busy, 1);
    check("send_c1", bus.tx_send, 0);
    cyc(1);
    check("send_c2", bus.tx_send, 1);
    check("hdr_c2", bus.tx_data, 8'hFE);
    wait_done("done_seen");
    check("busy_at_done", bus.busy, 0);
    bus.start = 1'b0;
    cyc(1);
    check("nbytes", n_send - base, n + 5);
    check("ndone", n_done - d0, 1);
    check("busy_after", bus.busy, 0);
    check("done_width", bus.done, 0);
    for (int i = 0; i < n + 5; i++)
      check($sformatf("byte%0d", i),
            bytes[(base + i) % 256], model(i, n, cmd));
  endtask

  initial begin
    int base;
    int s0;
    int d0;
    int e0;
    int k;
    logic [7:0] exp_b2b [14];

    bus.start = 1'b0;
    bus.payload_length = '0;
    bus.command_id = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    cyc(2);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_tx_send", bus.tx_send, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    reset = 1'b1;
    cyc(2);

    mem[0] = 8'h05;
    mem[1] = 8'h0A;
    frame(2, 8'h21, 1'b0, base);
    check("a_chk", bytes[base+5], 8'h2E);
    check("a_len", bytes[base+1], 8'h02);
    check("a_tail", bytes[base+6], 8'hEF);

    s0 = n_send;
    e0 = n_err;
    bus.payload_length = 8'd0;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check("err_n0", bus.error, 1);
    check("err_n0_busy", bus.busy, 0);
    cyc(1);
    check("err_width", bus.error, 0);
    bus.payload_length = 8'd17;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check("err_n17", bus.error, 1);
    check("err_n17_busy", bus.busy, 0);
    cyc(3);
    check("err_count", n_err - e0, 2);
    check("err_nosend", n_send - s0, 0);
    check("err_idle", bus.busy, 0);

    for (int i = 0; i < 16; i++) mem[i] = i[7:0];
    frame(16, 8'h00, 1'b0, base);
    check("m_chk", bytes[base+19], 8'h00);
    check("m_tail", bytes[base+20], 8'hEF);
    check("m_last_pay", bytes[base+18], 8'h0F);
    check("m_rd_addr", bus.rd_addr, 4'hF);
    check("m_no_wrap", addr_back, 0);

    mem[0] = 8'h33;
    mem[1] = 8'hC4;
    stray_en = 1'b1;
    frame(2, 8'h5A, 1'b1, base);
    stray_en = 1'b0;
    check("s_pay1", bytes[base+4], 8'hC4);
    check("s_chk", bytes[base+5], 8'hAD);
    cyc(3);
    check("s_no_extra", n_send - base, 7);

    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h44;
    base = n_send;
    d0 = n_done;
    bus.payload_length = 8'd3;
    bus.command_id = 8'h42;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    k = 0;
    while (n_send < base + 5 && k < 200) begin
      cyc(1);
      k++;
    end
    check("r_reach_pay1", n_send - base, 5);
    check("r_addr_pre", bus.rd_addr, 1);
    reset = 1'b0;
    #1;
    check("r_tx_data", bus.tx_data, 0);
    check("r_busy", bus.busy, 0);
    check("r_tx_send", bus.tx_send, 0);
    check("r_rd_addr", bus.rd_addr, 0);
    check("r_done", bus.done, 0);
    cyc(3);
    reset = 1'b1;
    cyc(3);
    check("r_no_send", n_send - base, 5);
    check("r_no_done", n_done - d0, 0);
    check("r_idle", bus.busy, 0);
    frame(3, 8'h42, 1'b0, base);
    check("r_chk", bytes[base+6], 8'h35);

    mem[0] = 8'h77;
    mem[1] = 8'h88;
    mem[2] = 8'h99;
    exp_b2b = '{8'hFE, 8'h01, 8'h10, 8'h77,
                8'h67, 8'hEF,
                8'hFE, 8'h03, 8'h80, 8'h77,
                8'h88, 8'h99, 8'hE6, 8'hEF};
    base = n_send;
    d0 = n_done;
    bus.payload_length = 8'd1;
    bus.command_id = 8'h10;
    bus.start = 1'b1;
    cyc(1);
    bus.payload_length = 8'd3;
    bus.command_id = 8'h80;
    wait_done("b_done1");
    cyc(1);
    check("b_idle_gap", bus.busy, 0);
    cyc(1);
    check("b_restart", bus.busy, 1);
    bus.start = 1'b0;
    cyc(1);
    check("b_send_hdr", bus.tx_send, 1);
    wait_done("b_done2");
    cyc(1);
    check("b_nbytes", n_send - base, 14);
    check("b_ndone", n_done - d0, 2);
    for (int i = 0; i < 14; i++)
      check($sformatf("b_byte%0d", i),
            bytes[(base + i) % 256], exp_b2b[i]);
    cyc(3);
    check("b_final_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
